// File: rtl/axis_fifo_if.sv
// axis_fifo_if: one AXI-Stream link (valid/ready handshake plus a packed beat).
//   valid  producer -> consumer  beat valid
//   ready  consumer -> producer  consumer accepts beat
//   data   producer -> consumer  WORDS packed words of WORD_W bits
// The master modport is the producing side and the slave modport is the consuming side.
interface axis_fifo_if #(
    parameter int WORD_W = 8,
    parameter int WORDS  = 1
);
    logic                           valid;
    logic                           ready;
    logic [WORDS-1:0][WORD_W-1:0]   data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/axis_fifo.sv
// axis_fifo: synchronous first-word-fall-through AXI-Stream FIFO.
//   clk    single clock, rising edge
//   rstn   asynchronous active-low reset (pointers/flags/count only, not storage)
//   s      slave stream: s.valid/s.data in, s.ready out
//   m      master stream: m.valid/m.data out, m.ready in
//   count  beats currently stored (registered)
// s.ready and m.valid are registered, so neither depends combinationally on
// s.valid or m.ready.
module axis_fifo #(
    parameter int WORD_W = 8,
    parameter int BUS_W  = 8,   // integer multiple of WORD_W
    parameter int DEPTH  = 8    // power of two, >= 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    axis_fifo_if.slave                 s,
    axis_fifo_if.master                m,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int WORDS_PER_BEAT = BUS_W / WORD_W;
    localparam int CNT_W          = $clog2(DEPTH + 1);
    localparam int AW             = $clog2(DEPTH);
    localparam int PW             = AW + 1;

    typedef logic [WORDS_PER_BEAT-1:0][WORD_W-1:0] beat_t;

    beat_t            mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             s_ready_q;
    logic             m_valid_q;
    logic [CNT_W-1:0] count_next;
    logic             push;
    logic             pop;

    assign push = s.valid && s_ready_q;
    assign pop  = m_valid_q && m.ready;

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + 1'b1;
        else if (pop && !push)
            count_next = count - 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count     <= count_next;
            s_ready_q <= (count_next != CNT_W'(DEPTH));
            m_valid_q <= (count_next != '0);
        end
    end

    // Storage has no reset; push is already gated by s_ready_q, which is low in reset.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= s.data;
    end

    // The pointer difference (modulo 2*DEPTH, MSB included) must always equal count.
    always_ff @(posedge clk) begin
        if (rstn)
            assert (CNT_W'(wr_ptr - rd_ptr) == count);
    end

    assign s.ready = s_ready_q;
    assign m.valid = m_valid_q;
    assign m.data  = mem[rd_ptr[AW-1:0]];
endmodule

// File: doc/axis_fifo.md
# axis_fifo

Synchronous first-word-fall-through AXI-Stream FIFO that decouples an AXIS producer from an AXIS consumer. It sits between the stream source (DMA/driver side) and the systolic-array input stage, so bursty `s_valid` and stalling `m_ready` are absorbed without losing or reordering beats. Beat format matches the rest of the stream path: `WORDS_PER_BEAT` packed words of `WORD_W` bits. Depth and occupancy are exposed for flow monitoring.

## Interface
- `WORD_W`, 8, bits per word
- `BUS_W`, 8, bits per beat; must be an integer multiple of `WORD_W`
- `DEPTH`, 8, beats of storage; power of two, ≥ 2
- `WORDS_PER_BEAT`, `BUS_W/WORD_W`, localparam
- `CNT_W`, `$clog2(DEPTH+1)`, localparam

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rstn`  in  1  asynchronous, active-low reset
- `s_valid`  in  1  upstream beat valid
- `s_ready`  out  1  FIFO can accept a beat
- `s_data`  in  `[WORDS_PER_BEAT-1:0][WORD_W-1:0]`  upstream beat
- `m_valid`  out  1  head beat available
- `m_ready`  in  1  downstream accepts head beat
- `m_data`  out  `[WORDS_PER_BEAT-1:0][WORD_W-1:0]`  head beat
- `count`  out  `CNT_W`  beats currently stored

## Operation
- Push when `s_valid && s_ready` at a rising edge: `s_data` is written at `wr_ptr`, and `wr_ptr` increments.
- Pop when `m_valid && m_ready` at a rising edge: `rd_ptr` increments.
- Pointers are `$clog2(DEPTH)+1` bits. Address is the low bits. The MSB distinguishes full from empty. Wrap-around is natural modulo `2*DEPTH`.
- `count` is a register:
  - +1 on push only
  - −1 on pop only
  - unchanged on simultaneous push and pop, or on neither.
- `s_ready`, `m_valid` and `count` are registered, derived from next-state occupancy:
  - `s_ready_next = (count_next != DEPTH)`
  - `m_valid_next = (count_next != 0)`
- `m_data = mem[rd_ptr addr]` is a combinational read of registered storage (FWFT). It holds stable while `m_valid && !m_ready`.
- Storage is not reset. `m_data` is don't-care while `m_valid=0`.
- Ordering: strict FIFO. No beat is dropped or duplicated.
- Full:
  - `s_ready=0`. A push attempt is ignored, and the producer must hold its beat.
  - A pop in the same cycle frees a slot, so `s_ready=1` next cycle.
  - There is no same-cycle bypass while full.
- Empty:
  - `m_valid=0`, so no pop is possible.
  - A push makes `m_valid=1` the next cycle. There is no combinational pass-through from `s_data` to `m_data`.
- Simultaneous push+pop at any occupancy `0<count<DEPTH`: both succeed, and `count`, `s_ready` and `m_valid` are unchanged.
- Reset (asynchronous, any time including mid-transfer):
  - Pointers, `count`, `s_ready` and `m_valid` clear immediately.
  - Stored beats are discarded.
  - No handshake completes while `rstn=0`.

## Timing
- Reset values: `s_ready=0`, `m_valid=0`, `count=0`, `m_data` = X.
- First rising edge with `rstn=1` sets `s_ready=1`. `m_valid` stays 0.
- Latency: a beat pushed at edge N is visible with `m_valid=1` after edge N (earliest pop at edge N+1). This is one cycle of fall-through latency.
- Throughput: one beat per cycle sustained in both directions when `0<count<DEPTH`.
- `s_ready` depends only on registers. It never depends combinationally on `s_valid` or `m_ready`.
- `m_valid` never depends combinationally on `m_ready`.
- Once asserted, `m_valid` stays high and `m_data` stays unchanged until the pop edge (AXIS rule).
- `count` reflects state after the last edge: `count==DEPTH` iff `s_ready==0` (post-reset), and `count==0` iff `m_valid==0`.

## Test plan
- **Reset/idle:**
  - Stimulus: hold `rstn=0` for 5 cycles, then release.
  - Required: during reset `s_ready=0`, `m_valid=0`, `count=0`. After the first edge with `rstn=1`, `s_ready=1` and `m_valid` stays 0.
- **Fill to full:**
  - Stimulus: `DEPTH=8`, `m_ready=0`, push 0x01..0x09 on back-to-back cycles.
  - Required: `count` steps 1..8. `s_ready=0` after the 8th push, and 0x09 is held, not accepted. `m_data=0x01`.
- **Drain and order:**
  - Stimulus: from full, `m_ready=1` for 8 cycles, then release 0x09.
  - Required: output sequence 0x01..0x09 with no gaps. `m_valid=0` and `count=0` once empty.
- **Simultaneous push/pop at full:**
  - Stimulus: `count=8`, `s_valid=1`, `m_ready=1`.
  - Required: pop succeeds and the push is refused that cycle. Next cycle `count=7` and `s_ready=1`.
- **Random traffic with wrap:**
  - Stimulus: 100 packets of 10 random bytes; source `PROB_VALID=1`…`100`, sink `PROB_READY=10`…`100`.
  - Required: received packets equal sent packets, with pointers wrapping many times.
- **Mid-stream reset:**
  - Stimulus: `count=5`, assert `rstn=0` asynchronously between edges.
  - Required: `m_valid`, `s_ready` and `count` drop to 0 without waiting for a clock edge. After release, the first beat out is the first beat pushed after reset.
